set_host: RTL and testbench

- Job sequencer that drives the circle-candidate engine from the initiator side.
- Accepts jobs (central, radius, mode) on a valid/ready input and issues each to the engine as a single-cycle en.
- Waits for the engine's valid pulse with a timeout, and returns candidate, mode echo and timeout status on a valid/ready result port.
- Keeps job and timeout statistics; sits between the test/control front-end and the engine.

---
 rtl/set_host_if.sv | 41 ++++
 rtl/set_host.sv | 166 ++++++++++++++++
 tb/tb_set_host.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/set_host_if.sv
// Job, engine and result signal bundle for the set_host sequencer.
// The master modport is the sequencer's view; slave is the environment's view.
interface set_host_if;
  logic        job_valid;
  logic        job_ready;
  logic [23:0] job_central;
  logic [11:0] job_radius;
  logic [1:0]  job_mode;

  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy;
  logic        set_valid;
  logic [7:0]  set_candidate;

  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_candidate;
  logic [1:0]  res_mode;
  logic        res_timeout;

  modport master (
    input  job_valid, job_central, job_radius, job_mode,
    output job_ready,
    output set_en, set_central, set_radius, set_mode,
    input  set_busy, set_valid, set_candidate,
    output res_valid, res_candidate, res_mode, res_timeout,
    input  res_ready
  );

  modport slave (
    output job_valid, job_central, job_radius, job_mode,
    input  job_ready,
    input  set_en, set_central, set_radius, set_mode,
    output set_busy, set_valid, set_candidate,
    input  res_valid, res_candidate, res_mode, res_timeout,
    output res_ready
  );
endinterface

// File: rtl/set_host.sv
// Job sequencer for the circle-candidate engine: accepts a job, strobes the engine once,
// waits for its result under a timeout and returns it on a valid/ready port.
module set_host #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned GAP     = 2
) (
  input  logic         clk,
  input  logic         rst,
  set_host_if.master   bus,
  output logic [15:0]  jobs_done,
  output logic [7:0]   timeouts,
  output logic         err_spurious
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StWait  = 3'd2,
    StResp  = 3'd3,
    StGap   = 3'd4
  } state_e;

  localparam logic [15:0] TimerLast = 16'(TIMEOUT - 1);
  localparam logic [15:0] GapLast   = (GAP == 0) ? 16'd0 : 16'(GAP - 1);

  state_e state_q, state_d;

  logic        set_en_q, set_en_d;
  logic [23:0] set_central_q, set_central_d;
  logic [11:0] set_radius_q, set_radius_d;
  logic [1:0]  set_mode_q, set_mode_d;
  logic        res_valid_q, res_valid_d;
  logic [7:0]  res_candidate_q, res_candidate_d;
  logic [1:0]  res_mode_q, res_mode_d;
  logic        res_timeout_q, res_timeout_d;
  logic [15:0] jobs_done_q, jobs_done_d;
  logic [7:0]  timeouts_q, timeouts_d;
  logic        err_q, err_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] gap_q, gap_d;

  logic accept;
  logic busy_unused;

  assign accept      = (state_q == StIdle) && bus.job_valid;
  assign busy_unused = bus.set_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (bus.set_valid || timer_q == TimerLast) state_d = StResp;
      StResp:  if (bus.res_ready) state_d = (GAP == 0) ? StIdle : StGap;
      StGap:   if (gap_q == GapLast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    set_en_d        = accept;
    set_central_d   = set_central_q;
    set_radius_d    = set_radius_q;
    set_mode_d      = set_mode_q;
    res_valid_d     = res_valid_q;
    res_candidate_d = res_candidate_q;
    res_mode_d      = res_mode_q;
    res_timeout_d   = res_timeout_q;
    jobs_done_d     = jobs_done_q;
    timeouts_d      = timeouts_q;
    err_d           = err_q;
    timer_d         = timer_q;
    gap_d           = gap_q;

    if (accept) begin
      set_central_d = bus.job_central;
      set_radius_d  = bus.job_radius;
      set_mode_d    = bus.job_mode;
    end

    if (state_q == StIssue) timer_d = 16'd0;

    if (state_q == StWait) begin
      timer_d = timer_q + 16'd1;
      // A result arriving on the expiry cycle still counts as a real result.
      if (bus.set_valid) begin
        res_valid_d     = 1'b1;
        res_candidate_d = bus.set_candidate;
        res_mode_d      = set_mode_q;
        res_timeout_d   = 1'b0;
        jobs_done_d     = jobs_done_q + 16'd1;
      end else if (timer_q == TimerLast) begin
        res_valid_d     = 1'b1;
        res_candidate_d = 8'd0;
        res_mode_d      = set_mode_q;
        res_timeout_d   = 1'b1;
        jobs_done_d     = jobs_done_q + 16'd1;
        if (timeouts_q != 8'hFF) timeouts_d = timeouts_q + 8'd1;
      end
    end else if (bus.set_valid) begin
      err_d = 1'b1;
    end

    if (state_q == StResp && bus.res_ready) begin
      res_valid_d = 1'b0;
      gap_d       = 16'd0;
    end

    if (state_q == StGap) gap_d = gap_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_en_q        <= 1'b0;
      set_central_q   <= 24'd0;
      set_radius_q    <= 12'd0;
      set_mode_q      <= 2'd0;
      res_valid_q     <= 1'b0;
      res_candidate_q <= 8'd0;
      res_mode_q      <= 2'd0;
      res_timeout_q   <= 1'b0;
      jobs_done_q     <= 16'd0;
      timeouts_q      <= 8'd0;
      err_q           <= 1'b0;
      timer_q         <= 16'd0;
      gap_q           <= 16'd0;
    end else begin
      set_en_q        <= set_en_d;
      set_central_q   <= set_central_d;
      set_radius_q    <= set_radius_d;
      set_mode_q      <= set_mode_d;
      res_valid_q     <= res_valid_d;
      res_candidate_q <= res_candidate_d;
      res_mode_q      <= res_mode_d;
      res_timeout_q   <= res_timeout_d;
      jobs_done_q     <= jobs_done_d;
      timeouts_q      <= timeouts_d;
      err_q           <= err_d;
      timer_q         <= timer_d;
      gap_q           <= gap_d;
    end
  end

  // Ready is decoded straight from the state flop so it is high right after reset release.
  assign bus.job_ready     = rst && (state_q == StIdle);
  assign bus.set_en        = set_en_q;
  assign bus.set_central   = set_central_q;
  assign bus.set_radius    = set_radius_q;
  assign bus.set_mode      = set_mode_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_candidate = res_candidate_q;
  assign bus.res_mode      = res_mode_q;
  assign bus.res_timeout   = res_timeout_q;
  assign jobs_done         = jobs_done_q;
  assign timeouts          = timeouts_q;
  assign err_spurious      = err_q;

endmodule

// File: tb/tb_set_host.sv
// Scoreboard bench for set_host: stimulus pushes expected results, a monitor pops and compares.
module tb_set_host;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned GAP     = 2;
  localparam int          NEVER   = 100000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] jobs_done;
  logic [7:0]  timeouts;
  logic        err_spurious;

  always #5 clk = ~clk;

  set_host_if bus();

  set_host #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .jobs_done    (jobs_done),
    .timeouts     (timeouts),
    .err_spurious (err_spurious)
  );

  typedef struct packed {
    logic [7:0] cand;
    logic [1:0] mode;
    logic       tout;
  } res_t;

  typedef struct {
    int         lat;
    logic [7:0] cand;
  } plan_t;

  res_t  sb[$];
  plan_t plan[$];
  int    total = 0;
  int    bad = 0;
  int    exp_jobs = 0;
  int    exp_touts = 0;
  int    gap_cnt = -1;
  int    rr_mode = 0;
  int    cyc = 0;
  int    acc_cyc = 0;
  bit    mon_en = 1'b0;
  res_t  mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: the engine answers within the window -> its candidate; otherwise an abort.
  function automatic res_t model(logic [1:0] m, int lat, logic [7:0] cand);
    res_t r;
    if (lat >= 0 && lat < int'(TIMEOUT)) r = '{cand: cand, mode: m, tout: 1'b0};
    else                                 r = '{cand: 8'd0, mode: m, tout: 1'b1};
    return r;
  endfunction

  // Engine stand-in: answers `lat` cycles into the wait window, or stays silent.
  initial begin
    plan_t p;
    bus.set_valid     = 1'b0;
    bus.set_candidate = 8'd0;
    bus.set_busy      = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && bus.set_en) begin
        if (plan.size() == 0) begin
          total++;
          bad++;
          $display("FAIL engine_start: got set_en with no job, expected none");
        end else begin
          p = plan.pop_front();
          bus.set_busy = 1'b1;
          @(posedge clk);
          if (p.lat < int'(TIMEOUT)) begin
            repeat (p.lat) @(posedge clk);
            #1;
            bus.set_valid     = 1'b1;
            bus.set_candidate = p.cand;
            @(posedge clk);
            #1;
            bus.set_valid = 1'b0;
          end
          bus.set_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rr_mode)
        0:       bus.res_ready = 1'($urandom_range(0, 1));
        1:       bus.res_ready = 1'b0;
        default: bus.res_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares presented results with the scoreboard head, pops on handshake.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (gap_cnt >= 0) begin
        gap_cnt++;
        if (gap_cnt == int'(GAP)) begin
          check("gap_ready_low", 64'(bus.job_ready), 64'd0);
        end else if (gap_cnt == int'(GAP) + 1) begin
          check("gap_ready_high", 64'(bus.job_ready), 64'd1);
          gap_cnt = -1;
        end
      end
      if (bus.res_valid) begin
        check("ready_low_in_resp", 64'(bus.job_ready), 64'd0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got res_valid=1, expected 0");
        end else begin
          mon_e = sb[0];
          check("res_candidate", 64'(bus.res_candidate), 64'(mon_e.cand));
          check("res_mode", 64'(bus.res_mode), 64'(mon_e.mode));
          check("res_timeout", 64'(bus.res_timeout), 64'(mon_e.tout));
          if (bus.res_ready) begin
            void'(sb.pop_front());
            exp_jobs = (exp_jobs + 1) & 16'hFFFF;
            if (mon_e.tout && exp_touts < 255) exp_touts++;
            check("jobs_done", 64'(jobs_done), 64'(exp_jobs));
            check("timeouts", 64'(timeouts), 64'(exp_touts));
            gap_cnt = 0;
          end
        end
      end
    end
  end

  task automatic issue_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                           input int lat, input logic [7:0] cand);
    int n = 0;
    @(negedge clk);
    bus.job_central = c;
    bus.job_radius  = r;
    bus.job_mode    = m;
    bus.job_valid   = 1'b1;
    while (!bus.job_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.job_ready) begin
      total++;
      bad++;
      $display("FAIL job_accept: got job_ready=0 for %0d cycles, expected 1", n);
      bus.job_valid = 1'b0;
      return;
    end
    plan.push_back('{lat: lat, cand: cand});
    sb.push_back(model(m, lat, cand));
    @(posedge clk);
    #1;
    bus.job_valid = 1'b0;
    acc_cyc = cyc;
    check("set_en_on", 64'(bus.set_en), 64'd1);
    check("set_fields", 64'({bus.set_central, bus.set_radius, bus.set_mode}), 64'({c, r, m}));
    check("ready_drop", 64'(bus.job_ready), 64'd0);
    @(posedge clk);
    #1;
    check("set_en_off", 64'(bus.set_en), 64'd0);
  endtask

  task automatic wait_result(input int exp_lat);
    int n = 0;
    while (!bus.res_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.res_valid) begin
      total++;
      bad++;
      $display("FAIL result_wait: got no res_valid, expected one");
    end else begin
      check("result_latency", 64'(cyc - acc_cyc), 64'(exp_lat));
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() > 0 || gap_cnt >= 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending results, expected 0", sb.size());
    end
  endtask

  initial begin
    bus.job_valid   = 1'b0;
    bus.job_central = 24'd0;
    bus.job_radius  = 12'd0;
    bus.job_mode    = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_job_ready", 64'(bus.job_ready), 64'd0);
    check("rst_outputs", 64'({bus.set_en, bus.set_central, bus.res_valid, bus.res_candidate}),
          64'd0);
    check("rst_counters", 64'({jobs_done, timeouts, err_spurious}), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(bus.job_ready), 64'd1);
    mon_en  = 1'b1;
    rr_mode = 2;

    issue_job(24'h440000, 12'h300, 2'd0, 4, 8'h1D);
    wait_result(6);
    wait_drain();

    rr_mode = 1;
    issue_job(24'h123456, 12'hABC, 2'd2, 2, 8'hA5);
    wait_result(4);
    repeat (20) @(negedge clk);
    rr_mode = 2;
    wait_drain();

    issue_job(24'h010203, 12'h111, 2'd3, NEVER, 8'hEE);
    wait_result(int'(TIMEOUT) + 1);
    wait_drain();
    check("timeout_count", 64'(timeouts), 64'd1);

    issue_job(24'h0A0B0C, 12'h222, 2'd1, int'(TIMEOUT) - 1, 8'h07);
    wait_result(int'(TIMEOUT) + 1);
    wait_drain();
    check("race_timeouts_kept", 64'(timeouts), 64'd1);

    rr_mode = 0;
    for (int i = 0; i < 60; i++) begin
      issue_job(24'($urandom), 12'($urandom), 2'($urandom), int'($urandom_range(0, TIMEOUT + 3)),
                8'($urandom));
    end
    wait_drain();
    check("no_spurious", 64'(err_spurious), 64'd0);

    rr_mode = 2;
    for (int i = 0; i < 300; i++) begin
      issue_job(24'($urandom), 12'($urandom), 2'($urandom), NEVER, 8'd0);
    end
    wait_drain();
    check("timeouts_saturated", 64'(timeouts), 64'hFF);
    check("jobs_done_total", 64'(jobs_done), 64'(exp_jobs));

    @(negedge clk);
    bus.set_valid     = 1'b1;
    bus.set_candidate = 8'h55;
    @(negedge clk);
    bus.set_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("err_spurious_set", 64'(err_spurious), 64'd1);

    issue_job(24'h445566, 12'h333, 2'd2, NEVER, 8'd0);
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    check("midjob_rst_ready", 64'(bus.job_ready), 64'd0);
    check("midjob_rst_outputs",
          64'({bus.set_en, bus.set_central, bus.set_radius, bus.set_mode, bus.res_valid}), 64'd0);
    check("midjob_rst_counters", 64'({jobs_done, timeouts, err_spurious}), 64'd0);
    sb.delete();
    plan.delete();
    exp_jobs  = 0;
    exp_touts = 0;
    gap_cnt   = -1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rerelease", 64'(bus.job_ready), 64'd1);
    mon_en = 1'b1;
    issue_job(24'h0F0F0F, 12'h456, 2'd1, 5, 8'h3C);
    wait_result(7);
    wait_drain();
    check("jobs_after_reset", 64'(jobs_done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
